// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF engine.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam int SETTLE_CYCLES = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int MAJ_PASSES    = 3;

endpackage

// File: rtl/ro_puf_if.sv
// Host-side request/response bundle of the PUF engine.
interface ro_puf_if #(
  parameter int SEL_W     = 4,
  parameter int CNT_W     = 12,
  parameter int WIN_W     = 12,
  parameter int RESP_BITS = 8
);
  logic                         start;
  logic [RESP_BITS*2*SEL_W-1:0] challenge;
  logic [WIN_W-1:0]             window;
  logic                         busy;
  logic                         done;
  logic [RESP_BITS-1:0]         response;
  logic [RESP_BITS-1:0]         tie_mask;
  logic [CNT_W-1:0]             count_a;
  logic [CNT_W-1:0]             count_b;

  modport master (
    output start, challenge, window,
    input  busy, done, response, tie_mask, count_a, count_b
  );

  modport slave (
    input  start, challenge, window,
    output busy, done, response, tie_mask, count_a, count_b
  );
endinterface

// File: rtl/ro_edge_counter.sv
// Synchroniser + rising-edge detect + saturating edge counter for one RO channel.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   rise;

  assign rise = sync[SYNC_STAGES-1] & ~prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ro};
      prev <= sync[SYNC_STAGES-1];
      if (clr)
        cnt <= '0;
      else if (en && rise && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ro_puf_engine.sv
// RO PUF response generator: per challenge pair, settle, count both ROs, compare.
// Build option RO_PUF_MAJORITY_EN: three passes per pair, bit is the majority vote.
module ro_puf_engine
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO    = 16,
  parameter int SEL_W     = $clog2(NUM_RO),
  parameter int CNT_W     = 12,
  parameter int WIN_W     = 12,
  parameter int RESP_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ro_puf_if.slave           bus,
  input  logic [NUM_RO-1:0] ro_in,
  output logic              ro_enable,
  output logic              ro_reset
);

  localparam int IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int PAIR_W = 2 * SEL_W;

  state_t                        state;
  logic [RESP_BITS*PAIR_W-1:0]   chal_q;
  logic [WIN_W-1:0]              win_q;
  logic [WIN_W-1:0]              tmr;
  logic [IDX_W-1:0]              idx;
  logic [SEL_W-1:0]              sel_a, sel_b;
  logic                          ro_a, ro_b;
  logic [CNT_W-1:0]              cnt_a, cnt_b;
  logic                          gt, eq;
  logic                          bit_done, bit_val, bit_tie;

`ifdef RO_PUF_MAJORITY_EN
  logic [1:0] pass, gt_acc, tie_acc;
`endif

  // Out-of-range selects read as a dead oscillator.
  always_comb begin
    sel_a = chal_q[int'(idx)*PAIR_W +: SEL_W];
    sel_b = chal_q[int'(idx)*PAIR_W + SEL_W +: SEL_W];
    ro_a  = (int'(sel_a) < NUM_RO) ? ro_in[sel_a] : 1'b0;
    ro_b  = (int'(sel_b) < NUM_RO) ? ro_in[sel_b] : 1'b0;
  end

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .ro(ro_a),
    .clr(state == S_SETTLE), .en(state == S_COUNT), .cnt(cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .ro(ro_b),
    .clr(state == S_SETTLE), .en(state == S_COUNT), .cnt(cnt_b)
  );

  assign gt = cnt_a > cnt_b;
  assign eq = cnt_a == cnt_b;

  always_comb begin
`ifdef RO_PUF_MAJORITY_EN
    bit_done = (pass == 2'(MAJ_PASSES - 1));
    bit_val  = (gt_acc + {1'b0, gt}) >= 2'd2;
    bit_tie  = (tie_acc + {1'b0, eq}) == 2'(MAJ_PASSES);
`else
    bit_done = 1'b1;
    bit_val  = gt;
    bit_tie  = eq;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      chal_q       <= '0;
      win_q        <= '0;
      tmr          <= '0;
      idx          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.response <= '0;
      bus.tie_mask <= '0;
      bus.count_a  <= '0;
      bus.count_b  <= '0;
      ro_enable    <= 1'b0;
      ro_reset     <= 1'b1;
`ifdef RO_PUF_MAJORITY_EN
      pass         <= '0;
      gt_acc       <= '0;
      tie_acc      <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          chal_q       <= bus.challenge;
          win_q        <= (bus.window == '0) ? WIN_W'(1) : bus.window;
          bus.response <= '0;
          bus.tie_mask <= '0;
          idx          <= '0;
          tmr          <= WIN_W'(SETTLE_CYCLES - 1);
          bus.busy     <= 1'b1;
          ro_enable    <= 1'b1;
          ro_reset     <= 1'b0;
          state        <= S_SETTLE;
`ifdef RO_PUF_MAJORITY_EN
          pass         <= '0;
          gt_acc       <= '0;
          tie_acc      <= '0;
`endif
        end
        S_SETTLE: begin
          if (tmr == '0) begin
            tmr   <= win_q - 1'b1;
            state <= S_COUNT;
          end else
            tmr <= tmr - 1'b1;
        end
        S_COUNT: begin
          if (tmr == '0) state <= S_COMPARE;
          else           tmr   <= tmr - 1'b1;
        end
        S_COMPARE: begin
          bus.count_a <= cnt_a;
          bus.count_b <= cnt_b;
          tmr         <= WIN_W'(SETTLE_CYCLES - 1);
`ifdef RO_PUF_MAJORITY_EN
          if (bit_done) begin
            pass    <= '0;
            gt_acc  <= '0;
            tie_acc <= '0;
          end else begin
            pass    <= pass + 2'd1;
            gt_acc  <= gt_acc + {1'b0, gt};
            tie_acc <= tie_acc + {1'b0, eq};
          end
`endif
          if (bit_done) begin
            bus.response[idx] <= bit_val;
            bus.tie_mask[idx] <= bit_tie;
          end
          if (bit_done && idx == IDX_W'(RESP_BITS - 1)) begin
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else begin
            if (bit_done) idx <= idx + 1'b1;
            state <= S_SETTLE;
          end
        end
        S_DONE: begin
          bus.busy  <= 1'b0;
          ro_enable <= 1'b0;
          ro_reset  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_engine.sv
// Scoreboard bench for ro_puf_engine: cycle-based RO models, expected results queued at launch.
module tb_ro_puf_engine;

  typedef struct {
    string      name;
    int         k;
    int         lat;
    logic [7:0] resp;
    logic [7:0] tie;
    int         ca_lo, ca_hi, cb_lo, cb_hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ro = '0;
  logic        ro_en_m, ro_rst_m, ro_en_s, ro_rst_s;
  int          half [16];
  int          ph   [16];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sbq [$];
  exp_t        sq  [$];

  ro_puf_if #(.SEL_W(4), .CNT_W(12), .WIN_W(12), .RESP_BITS(8)) bus ();
  ro_puf_if #(.SEL_W(4), .CNT_W(4),  .WIN_W(12), .RESP_BITS(8)) bus_s ();

  ro_puf_engine #(.NUM_RO(16), .SEL_W(4), .CNT_W(12), .WIN_W(12), .RESP_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ro_in(ro), .ro_enable(ro_en_m), .ro_reset(ro_rst_m)
  );

  ro_puf_engine #(.NUM_RO(16), .SEL_W(4), .CNT_W(4), .WIN_W(12), .RESP_BITS(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .ro_in(ro), .ro_enable(ro_en_s), .ro_reset(ro_rst_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator k toggles every half[k] clocks; half=0 holds it low.
  always @(negedge clk)
    for (int i = 0; i < 16; i++)
      if (half[i] == 0) begin
        ro[i] <= 1'b0;
        ph[i] <= 0;
      end else if (ph[i] >= half[i] - 1) begin
        ro[i] <= ~ro[i];
        ph[i] <= 0;
      end else
        ph[i] <= ph[i] + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int pb(input int w);
    int we;
    we = (w == 0) ? 1 : w;
`ifdef RO_PUF_MAJORITY_EN
    return 3 * (we + 5);
`else
    return we + 5;
`endif
  endfunction

  function automatic logic [63:0] pairs(input logic [3:0] a0, b0, a1, b1);
    logic [63:0] c;
    for (int i = 0; i < 8; i++)
      c[i*8 +: 8] = (i % 2 == 0) ? {b0, a0} : {b1, a1};
    return c;
  endfunction

  function automatic exp_t mk(input string n, input int w, input logic [7:0] r, t,
                              input int cal, cah, cbl, cbh);
    exp_t e;
    e.name = n; e.k = 0; e.lat = 1 + 8 * pb(w); e.resp = r; e.tie = t;
    e.ca_lo = cal; e.ca_hi = cah; e.cb_lo = cbl; e.cb_hi = cbh;
    return e;
  endfunction

  task automatic score(input exp_t e, input int d, input logic [7:0] r, t,
                       input int ca, cb);
    check({e.name, "_latency"}, 64'(d - e.k), 64'(e.lat));
    check({e.name, "_response"}, 64'(r), 64'(e.resp));
    check({e.name, "_tie_mask"}, 64'(t), 64'(e.tie));
    check({e.name, "_count_a_range"}, 64'(ca >= e.ca_lo && ca <= e.ca_hi), 64'd1);
    check({e.name, "_count_b_range"}, 64'(cb >= e.cb_lo && cb <= e.cb_hi), 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sbq.size() == 0) check("main_done_unexpected", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        score(e, cyc, bus.response, bus.tie_mask, int'(bus.count_a), int'(bus.count_b));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_s.done === 1'b1) begin
      if (sq.size() == 0) check("sat_done_unexpected", 64'd1, 64'd0);
      else begin
        e = sq.pop_front();
        score(e, cyc, bus_s.response, bus_s.tie_mask, int'(bus_s.count_a), int'(bus_s.count_b));
      end
    end
  end

  task automatic launch(input logic [63:0] chal, input logic [11:0] win, input exp_t e);
    @(negedge clk);
    bus.challenge = chal;
    bus.window    = win;
    bus.start     = 1'b1;
    e.k = cyc;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check({e.name, "_busy_at_accept"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic drain(input bit sat, input int budget);
    int n;
    n = 0;
    while ((sat ? sq.size() : sbq.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((sat ? sq.size() : sbq.size()) != 0) begin
      check(sat ? "sat_drain_timeout" : "main_drain_timeout", 64'd1, 64'd0);
      if (sat) sq.delete(); else sbq.delete();
    end
    @(negedge clk);
    check(sat ? "sat_busy_after_done" : "main_busy_after_done",
          64'(sat ? bus_s.busy : bus.busy), 64'd0);
  endtask

  initial begin
    logic [63:0] c35, c53_77, c77;
    int          d, n;
    exp_t        e;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.challenge = '0; bus.window = '0;
    bus_s.start = 1'b0; bus_s.challenge = '0; bus_s.window = '0;
    for (int i = 0; i < 16; i++) half[i] = 0;
    half[0] = 2; half[1] = 3; half[3] = 4; half[5] = 5; half[7] = 6;
    c35    = pairs(4'd3, 4'd5, 4'd3, 4'd5);
    c53_77 = pairs(4'd5, 4'd3, 4'd7, 4'd7);
    c77    = pairs(4'd7, 4'd7, 4'd7, 4'd7);

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_response", 64'(bus.response), 64'd0);
    check("rst_tie_mask", 64'(bus.tie_mask), 64'd0);
    check("rst_count_a", 64'(bus.count_a), 64'd0);
    check("rst_count_b", 64'(bus.count_b), 64'd0);
    check("rst_ro_enable", 64'(ro_en_m), 64'd0);
    check("rst_ro_reset", 64'(ro_rst_m), 64'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    launch(c35, 12'd80, mk("basic", 80, 8'hFF, 8'h00, 9, 11, 7, 9));
    drain(1'b0, 3000);

    launch(c53_77, 12'd80, mk("rev_tie", 80, 8'h00, 8'hAA, 5, 8, 5, 8));
    drain(1'b0, 3000);

    launch(c77, 12'd0, mk("win0", 0, 8'h00, 8'hFF, 0, 1, 0, 1));
    drain(1'b0, 3000);

    // A start pulse mid-run must not restart or queue a second run.
    launch(c35, 12'd80, mk("ignore_start", 80, 8'hFF, 8'h00, 9, 11, 7, 9));
    repeat (100) @(negedge clk);
    bus.challenge = c53_77; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain(1'b0, 3000);
    repeat (3) @(negedge clk);
    check("ignore_start_no_rerun", 64'(bus.busy), 64'd0);

    // Start held high: exactly one idle cycle between done and next busy.
    @(negedge clk);
    bus.challenge = c35; bus.window = 12'd80; bus.start = 1'b1;
    e = mk("held1", 80, 8'hFF, 8'h00, 9, 11, 7, 9);
    e.k = cyc;
    sbq.push_back(e);
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("held1_done_seen", 64'(bus.done === 1'b1), 64'd1);
    d = cyc;
    e = mk("held2", 80, 8'hFF, 8'h00, 9, 11, 7, 9);
    e.k = d + 1;
    sbq.push_back(e);
    @(negedge clk);
    check("held_idle_gap", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("held_rebusy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    drain(1'b0, 3000);

    // Reset in the middle of bit 3's count phase.
    launch(c35, 12'd80, mk("aborted", 80, 8'hFF, 8'h00, 9, 11, 7, 9));
    repeat (3 * pb(80) + 23) @(negedge clk);
    check("pre_reset_response", 64'(bus.response), 64'h07);
    rst_n = 1'b0;
    #1;
    sbq.delete();
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_response", 64'(bus.response), 64'd0);
    check("midrst_count_a", 64'(bus.count_a), 64'd0);
    check("midrst_ro_reset", 64'(ro_rst_m), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("midrst_stays_idle", 64'(bus.busy), 64'd0);
    launch(c35, 12'd80, mk("post_reset", 80, 8'hFF, 8'h00, 9, 11, 7, 9));
    drain(1'b0, 3000);

    // Narrow counters saturate on both channels -> tie.
    @(negedge clk);
    bus_s.challenge = pairs(4'd0, 4'd1, 4'd0, 4'd1);
    bus_s.window = 12'd200; bus_s.start = 1'b1;
    e = mk("sat", 200, 8'h00, 8'hFF, 15, 15, 15, 15);
    e.k = cyc;
    sq.push_back(e);
    @(negedge clk);
    bus_s.start = 1'b0;
    check("sat_busy_at_accept", 64'(bus_s.busy), 64'd1);
    drain(1'b1, 6000);

`ifdef RO_PUF_MAJORITY_EN
    // Pair 0 pass 2 sees swapped frequencies; majority still yields 1.
    launch(c35, 12'd80, mk("majority", 80, 8'hFF, 8'h00, 9, 11, 7, 9));
    repeat (pb(80) / 3) @(negedge clk);
    half[3] = 5; half[5] = 4;
    repeat (pb(80) / 3) @(negedge clk);
    half[3] = 4; half[5] = 5;
    drain(1'b0, 6000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
